median_feeder: RTL and testbench

MEDIAN_FEEDER -- requirements
Module: median_feeder

---
 rtl/median_feeder.sv | 123 ++++++++++++
 tb/tb_median_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/median_feeder.sv
// Raster pixel feeder for a 3x3 median stage: two line buffers build each window,
// then its nine pixels are serialised row-major; optional WIN_CNT via MEDIAN_FEEDER_WINCNT_EN.
module median_feeder #(
    parameter int W     = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] PIX_I,
    input  logic         PIX_VALID,
    output logic         PIX_READY,
    output logic [W-1:0] DO,
    output logic         DSO,
`ifdef MEDIAN_FEEDER_WINCNT_EN
    output logic [15:0]  WIN_CNT,
`endif
    input  logic         MED_DSO
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t         state, state_d;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [3:0]     idx;
    logic           ready, dso, accept, x_last, y_last, win_done;
    logic [W-1:0]   lb1 [IMG_W];
    logic [W-1:0]   lb2 [IMG_W];
    logic [W-1:0]   win [9];

    assign accept   = PIX_VALID && ready;
    assign x_last   = (x == XW'(IMG_W - 1));
    assign y_last   = (y == YW'(IMG_H - 1));
    assign win_done = (x >= XW'(2)) && (y >= YW'(2));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        ready   = 1'b0;
        dso     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept && win_done) state_d = SEND;
            end
            SEND: begin
                dso = 1'b1;
                if (idx == 4'd8) state_d = WAIT;
            end
            WAIT: begin
                if (MED_DSO) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PIX_READY = ready;
    assign DSO       = dso;
    assign DO        = dso ? win[idx] : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                  idx <= '0;
        else if (state != SEND)     idx <= '0;
        else if (idx == 4'd8)       idx <= '0;
        else                        idx <= idx + 4'd1;
    end

    // Line buffers hold no reset: rows of a new frame overwrite them before any window uses them.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb2[x] <= lb1[x];
            lb1[x] <= PIX_I;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]   <= win[3*r+1];
                win[3*r+1] <= win[3*r+2];
            end
            win[2] <= lb2[x];
            win[5] <= lb1[x];
            win[8] <= PIX_I;
        end
    end

`ifdef MEDIAN_FEEDER_WINCNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            WIN_CNT <= '0;
        else if (accept && x == '0 && y == '0)
            WIN_CNT <= '0;
        else if (state == IDLE && state_d == SEND)
            WIN_CNT <= WIN_CNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_median_feeder.sv
// Directed bench for median_feeder on a 4x4 image: frame table plus stall and reset sequences.
module tb_median_feeder;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [7:0] PIX_I;
    logic       PIX_VALID;
    logic       PIX_READY;
    logic [7:0] DO;
    logic       DSO;
    logic       MED_DSO;
    logic       auto_med, man_ack, auto_ack;
`ifdef MEDIAN_FEEDER_WINCNT_EN
    logic [15:0] WIN_CNT;
    int          wc_q[$];
`endif

    assign MED_DSO = auto_med | man_ack;

    median_feeder #(.W(8), .IMG_W(4), .IMG_H(4)) dut (
        .CLK(CLK), .nRST(nRST), .PIX_I(PIX_I), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .DO(DO), .DSO(DSO),
`ifdef MEDIAN_FEEDER_WINCNT_EN
        .WIN_CNT(WIN_CNT),
`endif
        .MED_DSO(MED_DSO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] base;
        bit         rnd;
        logic [7:0] exp [36];
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         do_bad = 0;
    logic [7:0] cap[$];
    int         runs[$];
    logic [7:0] win_ref [36];
    vec_t       vecs [3];

    // Monitor: collects the serialised windows and answers each one three cycles later.
    initial begin
        int  run = 0;
        int  cd = 0;
        bit  prev = 0;
        auto_med = 1'b0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                run = 0; cd = 0; prev = 0; auto_med = 1'b0;
            end else begin
                if (!DSO && DO != 8'd0) do_bad++;
                if (DSO) begin
`ifdef MEDIAN_FEEDER_WINCNT_EN
                    if (run == 0) wc_q.push_back(int'(WIN_CNT));
`endif
                    cap.push_back(DO);
                    run++;
                end else if (run > 0) begin
                    runs.push_back(run);
                    run = 0;
                end
                auto_med = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) auto_med = 1'b1;
                end
                if (prev && !DSO && auto_ack) cd = 3;
                prev = DSO;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic clear_q();
        cap.delete();
        runs.delete();
`ifdef MEDIAN_FEEDER_WINCNT_EN
        wc_q.delete();
`endif
    endtask

    // Offers pixels base+1..base+n; returns at the negedge after the last accept.
    task automatic stream(input logic [7:0] base, input int n, input bit rnd);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
            @(negedge CLK);
            PIX_VALID = rnd ? 1'($urandom_range(1)) : 1'b1;
            PIX_I     = PIX_VALID ? base + 8'(i + 1) : 8'hEE;
            if (PIX_VALID && PIX_READY) i++;
            cyc++;
        end
        @(negedge CLK);
        PIX_VALID = 1'b0;
        PIX_I     = 8'h00;
        if (i < n) chk("stream_timeout", i, n);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (!(PIX_READY && !DSO) && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= 200) chk("idle_timeout", cyc, 0);
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        chk({tag, "_nvals"}, cap.size(), 36);
        chk({tag, "_nwin"}, runs.size(), 4);
        for (int w = 0; w < 4; w++) begin
            int bad = -1;
            checks++;
            for (int k = 0; k < 9; k++)
                if (bad < 0 && (9*w + k >= cap.size() || cap[9*w+k] !== v.exp[9*w+k])) bad = k;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_win%0d pix%0d: got %0d expected %0d", tag, w, bad,
                         (9*w + bad < cap.size()) ? int'(cap[9*w+bad]) : -1, v.exp[9*w+bad]);
            end
        end
        for (int r = 0; r < runs.size(); r++) chk({tag, "_dso_len"}, runs[r], 9);
`ifdef MEDIAN_FEEDER_WINCNT_EN
        for (int r = 0; r < wc_q.size(); r++) chk({tag, "_wincnt"}, wc_q[r], r + 1);
        chk({tag, "_wincnt_final"}, int'(WIN_CNT), 4);
`endif
        clear_q();
    endtask

    initial begin
        int bad;
        win_ref = '{1, 2, 3, 5, 6, 7, 9, 10, 11,
                    2, 3, 4, 6, 7, 8, 10, 11, 12,
                    5, 6, 7, 9, 10, 11, 13, 14, 15,
                    6, 7, 8, 10, 11, 12, 14, 15, 16};
        vecs[0].base = 8'd0;   vecs[0].rnd = 1'b0;
        vecs[1].base = 8'd100; vecs[1].rnd = 1'b0;
        vecs[2].base = 8'd0;   vecs[2].rnd = 1'b1;
        for (int v = 0; v < 3; v++)
            for (int j = 0; j < 36; j++) vecs[v].exp[j] = win_ref[j] + vecs[v].base;

        PIX_VALID = 1'b0; PIX_I = 8'h00; man_ack = 1'b0; auto_ack = 1'b1;
        do_reset();
        @(negedge CLK);
        chk("rst_ready", int'(PIX_READY), 1);
        chk("rst_dso", int'(DSO), 0);
        chk("rst_do", int'(DO), 0);
`ifdef MEDIAN_FEEDER_WINCNT_EN
        chk("rst_wincnt", int'(WIN_CNT), 0);
`endif

        // Back-to-back frames with no reset in between, last one with random PIX_VALID.
        for (int v = 0; v < 3; v++) begin
            stream(vecs[v].base, 16, vecs[v].rnd);
            wait_idle();
            check_frame($sformatf("frame%0d", v), vecs[v]);
        end

        // Stalled median stage: feeder must hold off indefinitely.
        auto_ack = 1'b0;
        stream(8'd0, 11, 1'b0);
        repeat (9) @(negedge CLK);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            PIX_VALID = 1'b1;
            if (PIX_READY || DSO) bad++;
            @(negedge CLK);
        end
        PIX_VALID = 1'b0;
        chk("stall_hold", bad, 0);
        man_ack = 1'b1;
        @(negedge CLK);
        man_ack = 1'b0;
        chk("stall_release_ready", int'(PIX_READY), 1);
        auto_ack = 1'b1;

        // Reset in the 5th SEND cycle, then restream the frame from (0,0).
        do_reset();
        clear_q();
        stream(8'd0, 11, 1'b0);
        repeat (4) @(negedge CLK);
        chk("send5_dso_before", int'(DSO), 1);
        nRST = 1'b0;
        #1;
        chk("abort_dso", int'(DSO), 0);
        chk("abort_do", int'(DO), 0);
        @(negedge CLK);
        nRST = 1'b1;
        clear_q();
        stream(8'd0, 16, 1'b0);
        wait_idle();
        check_frame("restream", vecs[0]);

        chk("do_zero_when_idle", do_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
